// File: rtl/task_tx_buffer_pkg.sv
// Shared definitions for the task-to-UART store-and-forward buffer.
package task_pkg;

    localparam int TASK_DATA_WIDTH = 8;

    typedef struct packed {
        logic                       last;
        logic [TASK_DATA_WIDTH-1:0] data;
    } task_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/task_tx_buffer_if.sv
// Task-side byte stream, UART-side handshake and status of the tx buffer.
interface task_tx_buffer_if
    import task_pkg::*;
#(
    parameter int DATA_WIDTH = TASK_DATA_WIDTH,
    parameter int DEPTH      = 16
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  i_last;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_valid;
    logic                  o_tx_last;
    logic                  i_tx_ready;
    logic [CNT_W-1:0]      o_level;
    logic [CNT_W-1:0]      o_pkt_count;
    logic                  o_overflow;

    // master drives the task stream and the transmitter's ready
    modport master (
        output i_data, i_valid, i_last, i_tx_ready,
        input  o_tx_data, o_tx_valid, o_tx_last, o_level, o_pkt_count, o_overflow
    );

    modport slave (
        input  i_data, i_valid, i_last, i_tx_ready,
        output o_tx_data, o_tx_valid, o_tx_last, o_level, o_pkt_count, o_overflow
    );

endinterface

// File: rtl/task_tx_fifo_mem.sv
// DEPTH x (DATA_WIDTH+1) storage: synchronous write, asynchronous read,
// plus a dedicated port that only sets the last bit of an existing entry.
module task_tx_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wlast_i,
    input  logic                  patch_i,
    input  logic [AW-1:0]         paddr_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rlast_o
);
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic                  last_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_mem[waddr_i] <= wdata_i;
        end
    end

    // A patch only happens on a dropped byte, so it never coincides with a write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            last_mem[waddr_i] <= wlast_i;
        end else if (patch_i) begin
            last_mem[paddr_i] <= 1'b1;
        end
    end

    assign rdata_o = data_mem[raddr_i];
    assign rlast_o = last_mem[raddr_i];

endmodule

// File: rtl/task_tx_buffer.sv
// Store-and-forward buffer: bytes are presented to UART TX only once the
// packet they belong to has been completely stored.
module task_tx_buffer
    import task_pkg::*;
#(
    parameter int DATA_WIDTH = TASK_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    task_tx_buffer_if.slave bus
);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int AW    = $clog2(DEPTH);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      level_q, level_d;
    logic [CNT_W-1:0]      pkt_q, pkt_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic                  tx_valid, pop, push, full, drop, patch;
    logic                  pkt_inc, pkt_dec;

    always_comb begin
        tx_valid = (pkt_q != '0);
        pop      = tx_valid && bus.i_tx_ready;
        full     = (level_q == CNT_W'(DEPTH));
        push     = bus.i_valid && (!full || pop);
        drop     = bus.i_valid && full && !pop;
        // a dropped final byte closes the truncated packet so the drain cannot stall
        patch    = drop && bus.i_last;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + CNT_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - CNT_W'(1);
        end

        pkt_inc = (push && bus.i_last) || patch;
        pkt_dec = pop && head_last;
        pkt_d   = pkt_q;
        if (pkt_inc && !pkt_dec) begin
            pkt_d = pkt_q + CNT_W'(1);
        end else if (!pkt_inc && pkt_dec) begin
            pkt_d = pkt_q - CNT_W'(1);
        end

        ovf_d = ovf_q || drop;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pkt_q    <= pkt_d;
            ovf_q    <= ovf_d;
        end
    end

    task_tx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk_i   (i_clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.i_data),
        .wlast_i (bus.i_last),
        .patch_i (patch),
        .paddr_i (wr_ptr_q - AW'(1)),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_data),
        .rlast_o (head_last)
    );

    // last is gated with valid so it reads 0 on an empty or reset buffer
    assign bus.o_tx_data   = head_data;
    assign bus.o_tx_valid  = tx_valid;
    assign bus.o_tx_last   = tx_valid && head_last;
    assign bus.o_level     = level_q;
    assign bus.o_pkt_count = pkt_q;
    assign bus.o_overflow  = ovf_q;

endmodule

// File: doc/task_tx_buffer.md
Name: task_tx_buffer

Overview:
- Store-and-forward packet buffer directly downstream of a task stage.
- Accepts the task's output byte stream (data/valid/last) and holds bytes until a complete packet (last-flagged byte) is stored.
- Then drains that packet to the UART transmitter over a valid/ready handshake.
- Prevents the transmitter from starting a reply that the task has not finished producing.

Parameters:
- DATA_WIDTH, 8, width of each stored byte/word; matches the task output width.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the level and packet counters (derived, not overridden).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-high reset
- i_data  input  DATA_WIDTH  byte from task stage
- i_valid  input  1  i_data is valid this cycle; no backpressure toward the task
- i_last  input  1  qualifies i_data as final byte of a packet
- o_tx_data  output  DATA_WIDTH  head-of-FIFO byte to UART TX
- o_tx_valid  output  1  head byte belongs to a complete packet
- o_tx_last  output  1  head byte is the packet's last byte
- i_tx_ready  input  1  UART TX accepts o_tx_data this cycle
- o_level  output  CNT_W  entries currently stored
- o_pkt_count  output  CNT_W  complete packets currently stored
- o_overflow  output  1  sticky: at least one byte dropped since reset

Behaviour:
- Clocking and reset:
  - One clock domain, i_clk.
  - i_rst is asynchronous and active-high; on assertion all pointers and counters clear immediately, o_overflow=0, o_tx_valid=0, o_tx_last=0, o_level=0, o_pkt_count=0.
  - Memory contents are not reset; o_tx_data is don't-care while o_tx_valid=0.
  - Reset mid-packet discards everything, including partial packets.
- Storage:
  - Circular buffer of DEPTH entries, each {last, data}.
  - wr_ptr and rd_ptr wrap modulo DEPTH.
  - level counts 0..DEPTH.
- Push (write):
  - Occurs when i_valid=1 and (level<DEPTH or a pop occurs in the same cycle).
  - Writes {i_last, i_data} at wr_ptr, then wr_ptr+1.
- Pop (read):
  - Occurs when o_tx_valid=1 and i_tx_ready=1; advances rd_ptr.
- Output path:
  - o_tx_data and o_tx_last are the head entry (combinational read of mem[rd_ptr]).
  - o_tx_valid = (pkt_count>0).
  - Since pkt_count>0 implies level>0, valid never asserts on an empty buffer.
- Latency:
  - A last-flagged byte pushed at edge N makes o_tx_valid=1 after edge N, i.e. visible in cycle N+1.
  - Bytes of an incomplete packet are never presented.
- Packet counter:
  - +1 on push with i_last=1; -1 on pop with o_tx_last=1.
  - If both happen in the same cycle, net 0.
- Level counter:
  - +1 on push, -1 on pop; a simultaneous push and pop leaves it unchanged.
- Overflow (i_valid=1, level==DEPTH, no pop):
  - The byte is dropped and o_overflow is set (sticky until reset).
  - If the dropped byte has i_last=1, set the last bit of entry wr_ptr-1 and increment pkt_count. This closes the truncated packet so the drain cannot deadlock. Entry wr_ptr-1 is never the entry being read, because DEPTH>=2 and the buffer is full with no pop.
- Deadlock case:
  - A full buffer holding no complete packet (level==DEPTH, pkt_count==0) is legal.
  - It clears only via a dropped i_last (rule above) or reset.
- Handshake rules:
  - o_tx_data, o_tx_last and o_tx_valid stay stable while o_tx_valid=1 and i_tx_ready=0.
  - i_tx_ready may be high while o_tx_valid=0; this has no effect.
- Back-to-back packets:
  - Drain continues seamlessly across packet boundaries, one byte per cycle when i_tx_ready is held high.

Decomposition:
- Shared package task_pkg: DATA_WIDTH default constant, typedef of the stored entry struct {logic last; logic [DATA_WIDTH-1:0] data;}.
- One sub-module: task_tx_fifo_mem, the DEPTH x (DATA_WIDTH+1) storage with a synchronous write port, an asynchronous read port, and a separate single-bit write port for last-bit patching.
- Pointer, counter and overflow logic stay in the top module.

Test Plan:
- Incomplete packet held (DEPTH=16): push 0x11,0x22,0x33 with last only on 0x33, i_tx_ready=1 → o_tx_valid=0 until the cycle after 0x33 is pushed; then 0x11,0x22,0x33 on consecutive cycles with o_tx_last only on 0x33; o_pkt_count returns 0.
- Backpressure: one stored packet 0xA5,0x5A, i_tx_ready=0 for 5 cycles → o_tx_data=0xA5 and o_tx_valid=1 stable for all 5 cycles, o_level=2; ready=1 → two pops, o_level=0.
- Simultaneous events: push last byte of packet 2 in the same cycle as the pop of packet 1's last byte → o_pkt_count unchanged (1), o_level unchanged.
- Overflow with last (DEPTH=16): push 16 bytes 0x00..0x0F with no last and ready=0, then push 0xFF with last → 0xFF dropped, o_overflow=1, o_pkt_count=1, o_level=16; drain yields 0x00..0x0F with o_tx_last on 0x0F.
- Full plus pop: buffer full with 1 packet, push 0x77 in the same cycle as a pop → 0x77 stored, o_level stays 16, o_overflow stays 0.
- Async reset mid-drain: assert i_rst between clock edges after 3 of 8 bytes popped → o_tx_valid, o_level, o_pkt_count and o_overflow go to 0 immediately, without waiting for a clock edge; later pushes behave as from power-up.
